al_word_loader: RTL and testbench



---
 rtl/al_word_loader.sv | 183 ++++++++++++++++++
 tb/tb_al_word_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/al_word_loader.sv
// al_word_loader: executes single parameter-word loads for the auto-load
// sequencer; checks the header word, shifts data words into the config chain.
module al_word_loader #(
  parameter logic [5:0]        MAX_ADDR = 6'd33,
  parameter int                WORD_W   = 16,
  parameter int                RD_LAT   = 2,
  parameter logic [WORD_W-1:0] HDR_KEY  = 16'hA55A
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AL_ENA,
  input  logic              EXECUTE,
  input  logic [5:0]        AL_CNT,
  input  logic              CLR_AL_DONE,
  input  logic [WORD_W-1:0] RD_DATA,
  output logic              RD_EN,
  output logic [5:0]        RD_ADDR,
  output logic              BUSY,
  output logic              AL_DONE,
  output logic              HDR_ERR,
  output logic              SER_DO,
  output logic              SER_EN,
  output logic              UPDATE,
  output logic [5:0]        REG_SEL
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAITD,
    S_SHIFT,
    S_UPD
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
  localparam logic [5:0] BITS     = 6'(WORD_W);

  state_t            state, state_d;
  logic [5:0]        addr, addr_d;
  logic [2:0]        lat, lat_d;
  logic [5:0]        bitcnt, bitcnt_d;
  logic [WORD_W-1:0] shreg, shreg_d;
  logic              rd_en, rd_en_d;
  logic              busy, busy_d;
  logic              al_done, al_done_d;
  logic              hdr_err, hdr_err_d;
  logic              ser_en, ser_en_d;
  logic              update, update_d;
  logic [5:0]        reg_sel, reg_sel_d;
  logic              set_done;
  logic              set_err;

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    lat_d     = lat;
    bitcnt_d  = bitcnt;
    shreg_d   = shreg;
    rd_en_d   = rd_en;
    busy_d    = busy;
    ser_en_d  = ser_en;
    update_d  = update;
    reg_sel_d = reg_sel;
    set_done  = 1'b0;
    set_err   = 1'b0;

    unique case (state)
      S_IDLE: begin
        busy_d = 1'b0;
        if (EXECUTE && AL_ENA) begin
          addr_d  = AL_CNT;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          lat_d   = LAT_INIT;
          state_d = S_RD;
        end
      end
      S_RD: begin
        rd_en_d = 1'b0;
        state_d = S_WAITD;
      end
      S_WAITD: begin
        if (lat == 3'd1) begin
          if (addr == 6'd0) begin
            if (RD_DATA != HDR_KEY) begin
              set_done = 1'b1;
              set_err  = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            shreg_d  = RD_DATA;
            ser_en_d = 1'b1;
            bitcnt_d = BITS;
            state_d  = S_SHIFT;
          end
        end else begin
          lat_d = lat - 3'd1;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg[WORD_W-2:0], 1'b0};
        if (bitcnt == 6'd1) begin
          ser_en_d  = 1'b0;
          update_d  = 1'b1;
          reg_sel_d = addr - 6'd1;
          state_d   = S_UPD;
        end else begin
          bitcnt_d = bitcnt - 6'd1;
        end
      end
      S_UPD: begin
        update_d = 1'b0;
        busy_d   = 1'b0;
        if (addr == MAX_ADDR) begin
          set_done = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Session end mid-load: drop everything, commit nothing.
    if (state != S_IDLE && !AL_ENA) begin
      state_d  = S_IDLE;
      rd_en_d  = 1'b0;
      ser_en_d = 1'b0;
      update_d = 1'b0;
      busy_d   = 1'b0;
      shreg_d  = '0;
      set_done = 1'b0;
      set_err  = 1'b0;
    end

    // Sticky flags; a clear beats a simultaneous set.
    al_done_d = CLR_AL_DONE ? 1'b0 : (al_done | set_done);
    hdr_err_d = CLR_AL_DONE ? 1'b0 : (hdr_err | set_err);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      addr    <= '0;
      lat     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      al_done <= 1'b0;
      hdr_err <= 1'b0;
      ser_en  <= 1'b0;
      update  <= 1'b0;
      reg_sel <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      lat     <= lat_d;
      bitcnt  <= bitcnt_d;
      shreg   <= shreg_d;
      rd_en   <= rd_en_d;
      busy    <= busy_d;
      al_done <= al_done_d;
      hdr_err <= hdr_err_d;
      ser_en  <= ser_en_d;
      update  <= update_d;
      reg_sel <= reg_sel_d;
    end
  end

  assign RD_EN   = rd_en;
  assign RD_ADDR = addr;
  assign BUSY    = busy;
  assign AL_DONE = al_done;
  assign HDR_ERR = hdr_err;
  assign SER_DO  = shreg[WORD_W-1];
  assign SER_EN  = ser_en;
  assign UPDATE  = update;
  assign REG_SEL = reg_sel;

endmodule

// File: tb/tb_al_word_loader.sv
// tb_al_word_loader: directed loads with a queue of expected serial bits,
// commit pulses and end-of-load flag states checked by a monitor.
module tb_al_word_loader;

  logic        CLK;
  logic        RST_N;
  logic        AL_ENA;
  logic        EXECUTE;
  logic [5:0]  AL_CNT;
  logic        CLR_AL_DONE;
  logic [15:0] RD_DATA;
  logic        RD_EN;
  logic [5:0]  RD_ADDR;
  logic        BUSY;
  logic        AL_DONE;
  logic        HDR_ERR;
  logic        SER_DO;
  logic        SER_EN;
  logic        UPDATE;
  logic [5:0]  REG_SEL;

  al_word_loader dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .AL_ENA(AL_ENA),
    .EXECUTE(EXECUTE),
    .AL_CNT(AL_CNT),
    .CLR_AL_DONE(CLR_AL_DONE),
    .RD_DATA(RD_DATA),
    .RD_EN(RD_EN),
    .RD_ADDR(RD_ADDR),
    .BUSY(BUSY),
    .AL_DONE(AL_DONE),
    .HDR_ERR(HDR_ERR),
    .SER_DO(SER_DO),
    .SER_EN(SER_EN),
    .UPDATE(UPDATE),
    .REG_SEL(REG_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back('{0, int'(d[15-i]), 0, 0, 0});
    end
  endtask

  task automatic exp_upd(input int sel);
    q.push_back('{1, sel, 0, 0, 0});
  endtask

  task automatic exp_end(input int len, input int done,
                         input int err, input int pre);
    q.push_back('{2, len, done, err, pre});
  endtask

  task automatic pop(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, 0, 0, 0, 0};
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL evt: got kind %0d expected none", kind);
    end else begin
      e = q.pop_front();
      chk("evt_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  int blen  = 0;
  int rcnt  = 0;
  int pdone = 0;
  bit busy_q = 1'b0;

  // Monitor: compare each observable event against the queue head.
  always @(negedge CLK) begin
    ev_t e;
    bit  ok;
    if (RST_N) begin
      if (SER_EN) begin
        pop(0, e, ok);
        if (ok) chk("ser_do", int'(SER_DO), e.a);
      end
      if (UPDATE) begin
        pop(1, e, ok);
        if (ok) chk("reg_sel", int'(REG_SEL), e.a);
      end
      if (BUSY) begin
        blen++;
        if (RD_EN) rcnt++;
        pdone = int'(AL_DONE);
      end else if (busy_q) begin
        pop(2, e, ok);
        if (ok) begin
          chk("busy_len", blen, e.a);
          chk("rd_en_cyc", rcnt, 1);
          chk("al_done", int'(AL_DONE), e.b);
          chk("hdr_err", int'(HDR_ERR), e.c);
          chk("al_done_pre", pdone, e.d);
        end
        blen = 0;
        rcnt = 0;
      end
      busy_q = BUSY;
    end
  end

  // Issue one load; optional second strobe, clear and abort at given edges.
  task automatic run_load(input logic [5:0] a, input logic [15:0] d,
                          input int ex2, input int clr_e, input int ab_e);
    bit fin = 1'b0;
    @(negedge CLK);
    AL_CNT  = a;
    RD_DATA = d;
    EXECUTE = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (!BUSY) begin
        fin = 1'b1;
        break;
      end
      EXECUTE     = (k + 1 == ex2);
      CLR_AL_DONE = (k + 1 == clr_e);
      if (k + 1 == ab_e) AL_ENA = 1'b0;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: BUSY got 1 expected 0 within 60 cycles");
    end
    EXECUTE     = 1'b0;
    CLR_AL_DONE = 1'b0;
    AL_ENA      = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_after", int'(BUSY), 0);
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    CLR_AL_DONE = 1'b1;
    @(negedge CLK);
    CLR_AL_DONE = 1'b0;
    chk("clr_done", int'(AL_DONE), 0);
    chk("clr_err", int'(HDR_ERR), 0);
  endtask

  initial begin
    RST_N       = 1'b0;
    AL_ENA      = 1'b1;
    EXECUTE     = 1'b1;
    AL_CNT      = 6'd5;
    CLR_AL_DONE = 1'b0;
    RD_DATA     = 16'h0000;
    repeat (3) @(negedge CLK);
    chk("reset_outs",
        int'({RD_EN, RD_ADDR, BUSY, AL_DONE, HDR_ERR,
              SER_DO, SER_EN, UPDATE, REG_SEL}), 0);
    RST_N   = 1'b1;
    EXECUTE = 1'b0;
    @(negedge CLK);
    chk("idle_post_rst", int'({BUSY, RD_EN}), 0);

    exp_end(4, 0, 0, 0);
    run_load(6'd0, 16'hA55A, -1, -1, -1);

    exp_end(4, 1, 1, 1);
    run_load(6'd0, 16'h1234, -1, -1, -1);
    pulse_clr();

    exp_end(4, 0, 0, 0);
    run_load(6'd0, 16'h1234, -1, 3, -1);

    exp_bits(16'hC3A5, 16);
    exp_upd(4);
    exp_end(20, 0, 0, 0);
    run_load(6'd5, 16'hC3A5, -1, -1, -1);

    exp_bits(16'h0F0F, 16);
    exp_upd(32);
    exp_end(20, 1, 0, 0);
    run_load(6'd33, 16'h0F0F, 10, -1, -1);

    exp_bits(16'h9A5C, 8);
    exp_end(11, 1, 0, 1);
    run_load(6'd6, 16'h9A5C, -1, -1, 11);
    pulse_clr();

    exp_bits(16'h8001, 16);
    exp_upd(39);
    exp_end(20, 0, 0, 0);
    run_load(6'd40, 16'h8001, -1, -1, -1);

    repeat (3) @(negedge CLK);
    chk("queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
